reaction_game_ctrl: RTL and testbench
=====================================

Name: reaction_game_ctrl

Overview:
Sequencer for the LFSR-based random delay timer in the reaction-time game. Arms the timer, waits for its fire strobe, lights the GO indicator, then measures player reaction in ticks with false-start and timeout detection. Sits between the debounced buttons, the random timer (drives its en, consumes its rand_out) and the score/display logic.

Parameters:
CNT_W, 16, width of reaction_ticks.
TICK_DIV, 50000, clock cycles per reaction tick (1 ms at 50 MHz); must be >= 2.
REACT_TIMEOUT, 2000, reaction tick count at which the attempt ends as timeout; must be < 2**CNT_W.
MAX_WAIT, 8000000, watchdog: WAIT cycles before GO is forced. Must exceed the timer's 6,000,000-cycle maximum delay, and must also cover a zero draw, which never fires.
ARM_CYCLES, 2, cycles timer_en stays high in ARM so the timer reloads a fresh delay.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_btn  in  1  debounced start button, level; internally rising-edge detected.
react_btn  in  1  debounced reaction button, level; internally rising-edge detected.
timer_fire  in  1  rand_out of the random timer; high = delay elapsed.
timer_en  out  1  to the timer's en; high holds and reloads the timer.
led_go  out  1  GO indicator.
busy  out  1  high in ARM, WAIT, GO.
result_valid  out  1  one-cycle strobe, results updated.
reaction_ticks  out  CNT_W  measured reaction, completed ticks.
false_start  out  1  last attempt ended by pressing before GO.
timeout  out  1  last attempt ended by REACT_TIMEOUT.

Behaviour:
- Reset (async, rst_n=0): state IDLE; timer_en=1; led_go, busy, result_valid, false_start, timeout = 0; reaction_ticks=0; edge-detect registers, prescaler, watchdog and counters = 0. Reset is honoured mid-attempt.
- All outputs registered. Edges: X_edge = X & ~X_q, where X_q is the previous sample. A button held through a state change produces no new edge.
- IDLE: timer_en=1, led_go=0. start edge -> ARM. Results from the previous attempt are held.
- ARM: timer_en=1, busy=1. On entry, clear reaction_ticks, false_start and timeout. After ARM_CYCLES cycles -> WAIT, with the watchdog cleared.
- WAIT: timer_en=0, busy=1, watchdog increments each cycle. Priority order:
  1. react edge -> RESULT with false_start=1 and reaction_ticks=0.
  2. timer_fire=1 or watchdog==MAX_WAIT-1 -> GO.
  A react edge and timer_fire in the same cycle count as a false start.
- GO: led_go=1, busy=1, timer_en=0. Prescaler and tick counter are zeroed on entry. Prescaler counts 0..TICK_DIV-1; each wrap increments the tick counter.
  - react edge -> RESULT, reaction_ticks = tick counter value in that cycle.
  - Else, when the tick counter reaches REACT_TIMEOUT -> RESULT with timeout=1 and reaction_ticks=REACT_TIMEOUT.
  - A react edge in the same cycle the timeout is reached counts as a valid press.
  - The tick counter never exceeds REACT_TIMEOUT (no wrap).
- RESULT: single cycle. result_valid=1, led_go=0, busy=0, timer_en=1 -> IDLE. Results remain stable until the next ARM entry.
- Latency: the cycle after the edge is sampled, state moves to RESULT with result fields valid. The timer_fire -> led_go delay is 1 cycle.
- start edges while busy are ignored. react edges in IDLE or ARM are ignored.
- timer_fire is ignored outside WAIT.

Test Plan:
(Simulation parameters: TICK_DIV=4, REACT_TIMEOUT=10, MAX_WAIT=50, ARM_CYCLES=2.)
1. Reset: assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately: timer_en=1, all others 0. Repeat during GO -> returns to IDLE, led_go=0.
2. Normal attempt: start edge; timer_fire=1 on the 20th WAIT cycle; react edge 13 cycles after led_go rises -> result_valid one pulse, reaction_ticks=3, false_start=0, timeout=0, then IDLE with timer_en=1.
3. False start: react edge on WAIT cycle 5 -> false_start=1, reaction_ticks=0, led_go never asserted. Fire plus react in the same cycle -> same result.
4. Timeout: GO reached, no press -> 40 cycles after GO entry, timeout=1, reaction_ticks=10, result_valid pulses once.
5. Watchdog: timer_fire held 0 -> led_go rises after 50 WAIT cycles; attempt completes normally.
6. Ignored inputs: start edge during WAIT and GO, react held high from IDLE into GO, start held through RESULT -> no restart, no spurious false start, no spurious reaction result.

Source files
------------

// File: rtl/reaction_game_ctrl_if.sv
// Signal bundle between the reaction-game sequencer and the buttons, random timer and score logic.
// The slave modport is the controller's view; master is the surrounding system's view.
interface reaction_game_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start_btn;
    logic             react_btn;
    logic             timer_fire;
    logic             timer_en;
    logic             led_go;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] reaction_ticks;
    logic             false_start;
    logic             timeout;

    modport slave (
        input  start_btn,
        input  react_btn,
        input  timer_fire,
        output timer_en,
        output led_go,
        output busy,
        output result_valid,
        output reaction_ticks,
        output false_start,
        output timeout
    );

    modport master (
        output start_btn,
        output react_btn,
        output timer_fire,
        input  timer_en,
        input  led_go,
        input  busy,
        input  result_valid,
        input  reaction_ticks,
        input  false_start,
        input  timeout
    );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: arms the random delay timer, lights GO when it fires, then times the
// player's press in ticks, flagging false starts and timeouts. All outputs are registered.
module reaction_game_ctrl #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned REACT_TIMEOUT = 2000,
    parameter int unsigned MAX_WAIT      = 8000000,
    parameter int unsigned ARM_CYCLES    = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    reaction_game_ctrl_if.slave bus
);
    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned WD_W    = $clog2(MAX_WAIT + 1);
    localparam int unsigned ARM_W   = $clog2(ARM_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(TICK_DIV - 1);
    localparam logic [WD_W-1:0]    WD_LAST       = WD_W'(MAX_WAIT - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST      = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TICKS = CNT_W'(REACT_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWait,
        StGo,
        StResult
    } state_e;

    state_e             r_state;
    logic               r_start_q;
    logic               r_react_q;
    logic [ARM_W-1:0]   r_arm_cnt;
    logic [WD_W-1:0]    r_watchdog;
    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_tick;
    logic               r_timer_en;
    logic               r_led_go;
    logic               r_busy;
    logic               r_result_valid;
    logic [CNT_W-1:0]   r_ticks;
    logic               r_false_start;
    logic               r_timeout;

    logic w_start_edge;
    logic w_react_edge;

    assign w_start_edge = bus.start_btn & ~r_start_q;
    assign w_react_edge = bus.react_btn & ~r_react_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_start_q      <= 1'b0;
            r_react_q      <= 1'b0;
            r_arm_cnt      <= '0;
            r_watchdog     <= '0;
            r_presc        <= '0;
            r_tick         <= '0;
            r_timer_en     <= 1'b1;
            r_led_go       <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_ticks        <= '0;
            r_false_start  <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_start_q      <= bus.start_btn;
            r_react_q      <= bus.react_btn;
            r_result_valid <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_start_edge) begin
                        r_state       <= StArm;
                        r_busy        <= 1'b1;
                        r_timer_en    <= 1'b1;
                        r_arm_cnt     <= '0;
                        r_ticks       <= '0;
                        r_false_start <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end

                StArm: begin
                    if (r_arm_cnt == ARM_LAST) begin
                        r_state    <= StWait;
                        r_timer_en <= 1'b0;
                        r_watchdog <= '0;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end

                StWait: begin
                    r_watchdog <= r_watchdog + WD_W'(1);
                    // A press beats a simultaneous fire: it is still a false start.
                    if (w_react_edge) begin
                        r_state        <= StResult;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_timer_en     <= 1'b1;
                        r_false_start  <= 1'b1;
                        r_ticks        <= '0;
                    end else if (bus.timer_fire || (r_watchdog == WD_LAST)) begin
                        r_state  <= StGo;
                        r_led_go <= 1'b1;
                        r_presc  <= '0;
                        r_tick   <= '0;
                    end
                end

                StGo: begin
                    if (w_react_edge) begin
                        r_state        <= StResult;
                        r_result_valid <= 1'b1;
                        r_led_go       <= 1'b0;
                        r_busy         <= 1'b0;
                        r_timer_en     <= 1'b1;
                        r_ticks        <= r_tick;
                    end else if (r_tick == TIMEOUT_TICKS) begin
                        r_state        <= StResult;
                        r_result_valid <= 1'b1;
                        r_led_go       <= 1'b0;
                        r_busy         <= 1'b0;
                        r_timer_en     <= 1'b1;
                        r_timeout      <= 1'b1;
                        r_ticks        <= TIMEOUT_TICKS;
                    end else if (r_presc == PRESC_LAST) begin
                        r_presc <= '0;
                        r_tick  <= r_tick + CNT_W'(1);
                    end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                    end
                end

                StResult: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state    <= StIdle;
                    r_led_go   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_timer_en <= 1'b1;
                end
            endcase
        end
    end

    assign bus.timer_en       = r_timer_en;
    assign bus.led_go         = r_led_go;
    assign bus.busy           = r_busy;
    assign bus.result_valid   = r_result_valid;
    assign bus.reaction_ticks = r_ticks;
    assign bus.false_start    = r_false_start;
    assign bus.timeout        = r_timeout;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: planned attempts are turned into expected results by a
// reference model and queued; a monitor compares every result strobe against the queue.
module tb_reaction_game_ctrl;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned REACT_TIMEOUT = 10;
    localparam int unsigned MAX_WAIT      = 50;
    localparam int unsigned ARM_CYCLES    = 2;

    // kind: 0 fire then press/none, 1 false start, 2 watchdog (no fire), 3 react held from IDLE
    typedef struct {
        int kind;
        int f;
        int w;
        int k;
    } plan_t;

    typedef struct {
        int ticks;
        int fs;
        int to;
        int busy_cycles;
        int go_cycles;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    reaction_game_ctrl_if #(.CNT_W(CNT_W)) u_if ();

    reaction_game_ctrl #(
        .CNT_W        (CNT_W),
        .TICK_DIV     (TICK_DIV),
        .REACT_TIMEOUT(REACT_TIMEOUT),
        .MAX_WAIT     (MAX_WAIT),
        .ARM_CYCLES   (ARM_CYCLES)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic plan_t mk(int kind, int f, int w, int k);
        plan_t p;
        p.kind = kind;
        p.f    = f;
        p.w    = w;
        p.k    = k;
        return p;
    endfunction

    // Edge e is the e-th rising edge counting from the one that samples the start press.
    // ARM spans ARM_CYCLES cycles, so WAIT cycle j is sampled at edge ARM_CYCLES+1+j and
    // GO cycle k (after GO is entered on WAIT cycle g) at edge ARM_CYCLES+2+g+k.
    function automatic exp_t model(plan_t p, output int e_end, output int react_e,
                                   output int fire_e);
        exp_t x;
        int   go_at;
        int   limit;
        int   wait_cycles;
        limit   = int'(REACT_TIMEOUT * TICK_DIV);
        go_at   = (p.kind == 2) ? int'(MAX_WAIT) - 1 : p.f;
        fire_e  = (p.kind == 2) ? -1 : int'(ARM_CYCLES) + 1 + p.f;
        x.fs    = 0;
        x.to    = 0;
        if (p.kind == 1) begin
            x.ticks     = 0;
            x.fs        = 1;
            x.go_cycles = 0;
            wait_cycles = p.w + 1;
            e_end       = int'(ARM_CYCLES) + 1 + p.w;
            react_e     = e_end;
        end else begin
            wait_cycles = go_at + 1;
            if (p.kind != 3 && p.k <= limit) begin
                x.ticks     = p.k / int'(TICK_DIV);
                x.go_cycles = p.k + 1;
                e_end       = int'(ARM_CYCLES) + 2 + go_at + p.k;
                react_e     = e_end;
            end else begin
                x.ticks     = int'(REACT_TIMEOUT);
                x.to        = 1;
                x.go_cycles = limit + 1;
                e_end       = int'(ARM_CYCLES) + 2 + go_at + limit;
                react_e     = -1;
            end
        end
        x.busy_cycles = int'(ARM_CYCLES) + wait_cycles + x.go_cycles;
        return x;
    endfunction

    task automatic check_reset_outputs(string tag);
        check({tag, "_timer_en"}, int'(u_if.timer_en), 1);
        check({tag, "_led_go"}, int'(u_if.led_go), 0);
        check({tag, "_busy"}, int'(u_if.busy), 0);
        check({tag, "_result_valid"}, int'(u_if.result_valid), 0);
        check({tag, "_ticks"}, int'(u_if.reaction_ticks), 0);
        check({tag, "_false_start"}, int'(u_if.false_start), 0);
        check({tag, "_timeout"}, int'(u_if.timeout), 0);
    endtask

    // abort_e >= 0: assert reset mid-cycle after edge abort_e instead of completing.
    task automatic run_attempt(plan_t p, int abort_e);
        exp_t x;
        int   e_end, react_e, fire_e, s_hold, s2;
        bit   held, extra;
        x    = model(p, e_end, react_e, fire_e);
        held = (p.kind == 3);
        exp_q.push_back(x);
        s_hold = ($urandom_range(0, 3) == 0) ? e_end + 3 : int'($urandom_range(1, 3));
        extra  = (s_hold <= 3) && (e_end >= 4) && ($urandom_range(0, 1) == 1);
        s2     = extra ? int'($urandom_range(4, e_end)) : -10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            u_if.start_btn  = 1'b0;
            u_if.timer_fire = 1'b0;
            u_if.react_btn  = held;
        end
        for (int e = 0; e <= e_end + 3; e++) begin
            @(negedge clk);
            u_if.start_btn  = (e < s_hold) || (e >= s2 && e <= s2 + 1);
            u_if.timer_fire = (fire_e >= 0) && (e >= fire_e) && (e <= e_end);
            u_if.react_btn  = held || ((react_e >= 0) && (e >= react_e) && (e <= react_e + 1));
            if (e == abort_e) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("midgo_reset");
                void'(exp_q.pop_back());
                u_if.start_btn  = 1'b0;
                u_if.timer_fire = 1'b0;
                u_if.react_btn  = 1'b0;
                @(negedge clk);
                check("midgo_reset_held_led_go", int'(u_if.led_go), 0);
                @(negedge clk);
                #1 rst_n = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: scoreboard pops on each result strobe; also tracks cycle counts per attempt.
    initial begin
        int   bcnt;
        int   gcnt;
        bit   prev_rv;
        exp_t x;
        bcnt    = 0;
        gcnt    = 0;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt    = 0;
                gcnt    = 0;
                prev_rv = 1'b0;
            end else begin
                if (u_if.busy) bcnt++;
                if (u_if.led_go) gcnt++;
                if (u_if.busy && bcnt == 1) begin
                    check("arm_clear_ticks", int'(u_if.reaction_ticks), 0);
                    check("arm_clear_false_start", int'(u_if.false_start), 0);
                    check("arm_clear_timeout", int'(u_if.timeout), 0);
                end
                check("timer_en", int'(u_if.timer_en),
                      (u_if.busy && bcnt > int'(ARM_CYCLES)) ? 0 : 1);
                if (prev_rv) check("result_valid_single_pulse", int'(u_if.result_valid), 0);
                if (u_if.result_valid) begin
                    check("result_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        check("reaction_ticks", int'(u_if.reaction_ticks), x.ticks);
                        check("false_start", int'(u_if.false_start), x.fs);
                        check("timeout", int'(u_if.timeout), x.to);
                        check("busy_cycles", bcnt, x.busy_cycles);
                        check("go_cycles", gcnt, x.go_cycles);
                        check("result_led_go", int'(u_if.led_go), 0);
                        check("result_busy", int'(u_if.busy), 0);
                    end
                    bcnt = 0;
                    gcnt = 0;
                end
                prev_rv = u_if.result_valid;
            end
        end
    end

    initial begin
        plan_t dir_q[$];
        plan_t p;
        int    f;
        n_tests         = 0;
        n_fail          = 0;
        u_if.start_btn  = 1'b0;
        u_if.react_btn  = 1'b0;
        u_if.timer_fire = 1'b0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        dir_q.push_back(mk(0, 19, 0, 13));  // ticks 3
        dir_q.push_back(mk(1, 19, 5, 0));   // false start
        dir_q.push_back(mk(1, 12, 12, 0));  // fire and press together
        dir_q.push_back(mk(0, 7, 0, 99));   // timeout
        dir_q.push_back(mk(2, 0, 0, 20));   // watchdog then press
        dir_q.push_back(mk(3, 10, 0, 0));   // react held from IDLE
        dir_q.push_back(mk(0, 3, 0, 40));   // press on the timeout cycle
        dir_q.push_back(mk(0, 0, 0, 0));
        foreach (dir_q[i]) run_attempt(dir_q[i], -1);

        // Reset during GO (GO cycle 6 of an attempt that would time out), then recover.
        run_attempt(mk(0, 5, 0, 99), int'(ARM_CYCLES) + 2 + 5 + 6);
        run_attempt(mk(0, 9, 0, 21), -1);

        for (int i = 0; i < 24; i++) begin
            f = int'($urandom_range(0, 45));
            p = mk(int'($urandom_range(0, 3)), f, int'($urandom_range(0, f)),
                   int'($urandom_range(0, 48)));
            run_attempt(p, -1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
